// File: rtl/param_traffic_light_controller.sv
// rtl/param_traffic_light_controller.sv - highway/local-road traffic light controller with pedestrian walk and flash mode
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   lr_has_car - local-road vehicle sensor
//   ped_req    - pedestrian crossing request (a one-cycle pulse is enough)
//   flash_en   - maintenance flash mode enable (level)
//   hw_light   - highway light, one-hot {green,yellow,red}
//   lr_light   - local-road light, one-hot {green,yellow,red}
//   ped_walk   - walk signal for the local-road crossing
module param_traffic_light_controller #(
    parameter int HW_GREEN   = 70,
    parameter int LR_GREEN   = 25,
    parameter int YELLOW     = 25,
    parameter int ALL_RED    = 1,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lr_has_car,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [2:0] hw_light,
    output logic [2:0] lr_light,
    output logic       ped_walk
);

    localparam int MAX_A   = (HW_GREEN > LR_GREEN) ? HW_GREEN : LR_GREEN;
    localparam int MAX_B   = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_DUR = (MAX_C > FLASH_HALF) ? MAX_C : FLASH_HALF;
    localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [CW-1:0] HW_M1 = CW'(HW_GREEN - 1);
    localparam logic [CW-1:0] LR_M1 = CW'(LR_GREEN - 1);
    localparam logic [CW-1:0] YE_M1 = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_M1 = CW'(ALL_RED - 1);
    localparam logic [CW-1:0] FH_M1 = CW'(FLASH_HALF - 1);

    localparam logic [2:0] GREEN = 3'b100;
    localparam logic [2:0] AMBER = 3'b010;
    localparam logic [2:0] RED   = 3'b001;
    localparam logic [2:0] DARK  = 3'b000;

    typedef enum logic [2:0] {
        S_HG,
        S_HY,
        S_AR1,
        S_LG,
        S_LY,
        S_AR2,
        S_FLASH
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          flash_phase, phase_next;
    logic          req_pending, req_next;
    logic          ped_pending, ped_next;
    logic          walk_next;
    logic [2:0]    hw_next, lr_next;
    logic          entry;

    always_comb begin
        next_state = state;
        cnt_next   = (cnt == '0) ? '0 : cnt - CW'(1);
        phase_next = flash_phase;
        hw_next    = RED;
        lr_next    = RED;

        // flash_en beats every timed transition, from any state
        if (flash_en) begin
            next_state = S_FLASH;
        end else begin
            case (state)
                S_HG:    if (cnt == '0 && req_pending) next_state = S_HY;
                S_HY:    if (cnt == '0) next_state = S_AR1;
                S_AR1:   if (cnt == '0) next_state = S_LG;
                S_LG:    if (cnt == '0) next_state = S_LY;
                S_LY:    if (cnt == '0) next_state = S_AR2;
                S_AR2:   if (cnt == '0) next_state = S_HG;
                S_FLASH: next_state = S_AR2;
                default: next_state = S_HG;
            endcase
        end

        entry = (next_state != state);

        if (entry) begin
            case (next_state)
                S_HG:    cnt_next = HW_M1;
                S_HY:    cnt_next = YE_M1;
                S_AR1:   cnt_next = AR_M1;
                S_LG:    cnt_next = LR_M1;
                S_LY:    cnt_next = YE_M1;
                S_AR2:   cnt_next = AR_M1;
                S_FLASH: cnt_next = FH_M1;
                default: cnt_next = HW_M1;
            endcase
            if (next_state == S_FLASH) phase_next = 1'b0;
        end else if (state == S_FLASH && cnt == '0) begin
            // flash half-period elapsed: flip lamp phase and rearm
            phase_next = ~flash_phase;
            cnt_next   = FH_M1;
        end

        // clearing on HY entry wins over a same-cycle request
        req_next  = (entry && next_state == S_HY) ? 1'b0 : (req_pending | lr_has_car | ped_req);
        // a request coinciding with LG entry belongs to the next LG
        ped_next  = (entry && next_state == S_LG) ? ped_req : (ped_pending | ped_req);
        walk_next = (next_state == S_LG) ? (entry ? ped_pending : ped_walk) : 1'b0;

        case (next_state)
            S_HG:    begin hw_next = GREEN; lr_next = RED;   end
            S_HY:    begin hw_next = AMBER; lr_next = RED;   end
            S_LG:    begin hw_next = RED;   lr_next = GREEN; end
            S_LY:    begin hw_next = RED;   lr_next = AMBER; end
            S_FLASH: begin
                hw_next = phase_next ? DARK : AMBER;
                lr_next = phase_next ? DARK : AMBER;
            end
            default: begin hw_next = RED;   lr_next = RED;   end
        endcase
    end

    // outputs are registered alongside the state so they always decode it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HG;
            cnt         <= HW_M1;
            flash_phase <= 1'b0;
            req_pending <= 1'b0;
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
            hw_light    <= GREEN;
            lr_light    <= RED;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            flash_phase <= phase_next;
            req_pending <= req_next;
            ped_pending <= ped_next;
            ped_walk    <= walk_next;
            hw_light    <= hw_next;
            lr_light    <= lr_next;
        end
    end

endmodule

// File: tb/tb_param_traffic_light_controller.sv
// tb/tb_param_traffic_light_controller.sv - self-checking bench for param_traffic_light_controller
module tb_param_traffic_light_controller;

    localparam int P_HG = 8;
    localparam int P_LG = 6;
    localparam int P_Y  = 3;
    localparam int P_AR = 2;
    localparam int P_FH = 4;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lr_has_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] hw_light, lr_light;
    logic       ped_walk;

    int checks = 0;
    int errors = 0;

    param_traffic_light_controller #(
        .HW_GREEN(P_HG), .LR_GREEN(P_LG), .YELLOW(P_Y), .ALL_RED(P_AR), .FLASH_HALF(P_FH)
    ) dut (
        .clk(clk), .rst(rst), .lr_has_car(lr_has_car), .ped_req(ped_req), .flash_en(flash_en),
        .hw_light(hw_light), .lr_light(lr_light), .ped_walk(ped_walk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: phase name plus the number of cycles already shown in it.
    typedef enum int {M_HG, M_HY, M_AR1, M_LG, M_LY, M_AR2, M_FL} mmode_t;
    mmode_t m_mode = M_HG;
    int     m_elapsed = 1;
    bit     m_req = 0, m_ped = 0, m_walk = 0, m_valid = 0;

    always @(posedge clk) begin
        mmode_t nxt;
        if (rst) begin
            m_mode = M_HG; m_elapsed = 1; m_req = 0; m_ped = 0; m_walk = 0; m_valid = 1;
        end else begin
            nxt = m_mode;
            if (flash_en) nxt = M_FL;
            else if (m_mode == M_FL) nxt = M_AR2;
            else begin
                case (m_mode)
                    M_HG:  if (m_elapsed >= P_HG && m_req) nxt = M_HY;
                    M_HY:  if (m_elapsed == P_Y)  nxt = M_AR1;
                    M_AR1: if (m_elapsed == P_AR) nxt = M_LG;
                    M_LG:  if (m_elapsed == P_LG) nxt = M_LY;
                    M_LY:  if (m_elapsed == P_Y)  nxt = M_AR2;
                    M_AR2: if (m_elapsed == P_AR) nxt = M_HG;
                    default: nxt = M_HG;
                endcase
            end
            if (nxt == M_LG && m_mode != M_LG) begin
                m_walk = m_ped;
                m_ped  = ped_req;
            end else begin
                if (nxt != M_LG) m_walk = 0;
                m_ped = m_ped | ped_req;
            end
            if (nxt == M_HY && m_mode != M_HY) m_req = 0;
            else m_req = m_req | lr_has_car | ped_req;
            m_elapsed = (nxt != m_mode) ? 1 : m_elapsed + 1;
            m_mode = nxt;
        end
    end

    function automatic logic [2:0] model_hw();
        case (m_mode)
            M_HG: return G;
            M_HY: return Y;
            M_FL: return (((m_elapsed - 1) / P_FH) % 2 == 0) ? Y : D;
            default: return R;
        endcase
    endfunction

    function automatic logic [2:0] model_lr();
        case (m_mode)
            M_LG: return G;
            M_LY: return Y;
            M_FL: return (((m_elapsed - 1) / P_FH) % 2 == 0) ? Y : D;
            default: return R;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_hw", -1, hw_light, model_hw());
            check("cmp_lr", -1, lr_light, model_lr());
            check("cmp_walk", -1, {2'b00, ped_walk}, {2'b00, m_walk});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; lr_has_car = 0; ped_req = 0; flash_en = 0;
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [2:0] t1_hw(input int i);
        if (i < 8) return G;
        if (i < 11) return Y;
        if (i < 24) return R;
        if (i < 32) return G;
        return Y;
    endfunction

    function automatic logic [2:0] t1_lr(input int i);
        if (i < 13) return R;
        if (i < 19) return G;
        if (i < 22) return Y;
        return R;
    endfunction

    initial begin
        // reset state and continuous local-road demand
        do_reset();
        check("reset_hw", 0, hw_light, G);
        check("reset_lr", 0, lr_light, R);
        check("reset_walk", 0, {2'b00, ped_walk}, 3'b000);
        for (int i = 0; i <= 33; i++) begin
            lr_has_car = 1;
            check("t1_hw", i, hw_light, t1_hw(i));
            check("t1_lr", i, lr_light, t1_lr(i));
            check("t1_model_hw", i, model_hw(), t1_hw(i));
            check("t1_model_lr", i, model_lr(), t1_lr(i));
            @(negedge clk);
        end

        // no demand: highway green forever
        do_reset();
        for (int i = 0; i < 100; i++) begin
            check("t2_hw", i, hw_light, G);
            check("t2_lr", i, lr_light, R);
            @(negedge clk);
        end

        // single-cycle car pulse is latched
        do_reset();
        for (int i = 0; i < 26; i++) begin
            lr_has_car = (i == 3);
            if (i == 7) check("t3_hw7", i, hw_light, G);
            if (i == 8) check("t3_hw8", i, hw_light, Y);
            if (i == 13) check("t3_lr13", i, lr_light, G);
            check("t3_walk", i, {2'b00, ped_walk}, 3'b000);
            @(negedge clk);
        end

        // pedestrian pulse gives walk for the whole LG dwell
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ped_req = (i == 5);
            check("t4_walk", i, {2'b00, ped_walk}, (i >= 13 && i <= 18) ? 3'b001 : 3'b000);
            if (i == 8) check("t4_hw8", i, hw_light, Y);
            @(negedge clk);
        end

        // flash entered during LG, released later
        do_reset();
        for (int i = 0; i <= 42; i++) begin
            lr_has_car = 1;
            flash_en = (i >= 14 && i < 30);
            if (i >= 15 && i <= 30) begin
                check("t5_fl_hw", i, hw_light, (((i - 15) / 4) % 2 == 0) ? Y : D);
                check("t5_fl_lr", i, lr_light, (((i - 15) / 4) % 2 == 0) ? Y : D);
            end
            if (i == 31 || i == 32) begin
                check("t5_ar_hw", i, hw_light, R);
                check("t5_ar_lr", i, lr_light, R);
            end
            if (i >= 33 && i <= 40) check("t5_hg", i, hw_light, G);
            if (i == 41) check("t5_hy", i, hw_light, Y);
            if (i == 13 || i == 14) check("t5_lg", i, lr_light, G);
            check("t5_walk", i, {2'b00, ped_walk}, 3'b000);
            @(negedge clk);
        end
        flash_en = 0;

        // reset during HY with demand held: HG minimum restarts
        do_reset();
        for (int i = 0; i <= 19; i++) begin
            lr_has_car = 1;
            rst = (i == 9);
            if (i == 9) check("t6a_hy", i, hw_light, Y);
            if (i >= 10 && i <= 17) check("t6a_hg", i, hw_light, G);
            if (i == 10) check("t6a_lr", i, lr_light, R);
            if (i == 18) check("t6a_hy2", i, hw_light, Y);
            @(negedge clk);
        end
        rst = 0;

        // reset clears a request latched during HY
        do_reset();
        for (int i = 0; i <= 60; i++) begin
            lr_has_car = (i < 4) || (i == 8);
            rst = (i == 9);
            if (i >= 10) begin
                check("t6b_hw", i, hw_light, G);
                check("t6b_lr", i, lr_light, R);
            end
            @(negedge clk);
        end
        rst = 0; lr_has_car = 0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
